// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the 8085 register-file micro-sequencer:
// opcodes, register/pair codes, sequencer states and pair address helpers.
package rf_pkg;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_INX = 2'b10;
  localparam logic [1:0] OP_DCX = 2'b11;

  localparam logic [2:0] REG_B         = 3'd1;
  localparam logic [2:0] REG_C         = 3'd2;
  localparam logic [2:0] REG_D         = 3'd3;
  localparam logic [2:0] REG_E         = 3'd4;
  localparam logic [2:0] REG_H         = 3'd5;
  localparam logic [2:0] REG_L         = 3'd6;
  localparam logic [2:0] REG_PAIR_ADDR = 3'd7;

  localparam logic [1:0] RP_BC = 2'd0;
  localparam logic [1:0] RP_DE = 2'd1;
  localparam logic [1:0] RP_HL = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SRC,
    ST_WR_DST,
    ST_RD_LO,
    ST_RD_HI,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE,
    ST_ERR
  } state_e;

  // Codes 0 and 7 never name a general register.
  function automatic logic reg_code_ok(input logic [2:0] code);
    return (code != 3'd0) && (code != REG_PAIR_ADDR);
  endfunction

  // Low byte of a pair sits at the even code above the high byte.
  function automatic logic [2:0] pair_lo(input logic [1:0] rp);
    return {rp, 1'b0} + 3'd2;
  endfunction

  function automatic logic [2:0] pair_hi(input logic [1:0] rp);
    return {rp, 1'b0} + 3'd1;
  endfunction

endpackage

// File: rtl/regfile_seq_rp_incdec.sv
// 16-bit register-pair increment/decrement, wrapping modulo 2^16, no flags.
// Purely combinational so the PC/SP datapaths can reuse it.
module rp_incdec (
  input  logic [7:0] hi_i,
  input  logic [7:0] lo_i,
  input  logic       dec_i,
  output logic [7:0] new_hi_o,
  output logic [7:0] new_lo_o
);

  logic [15:0] sum;

  // Adding all-ones is a decrement by one in two's complement.
  assign sum = {hi_i, lo_i} + (dec_i ? 16'hFFFF : 16'h0001);
  assign {new_hi_o, new_lo_o} = sum;

endmodule

// File: rtl/regfile_seq.sv
// Micro-sequencer executing MOV/MVI/INX/DCX on the 8085 B..L register file
// through a granted shared data bus (split in/out/oe interface).
module regfile_seq
  import rf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              rf_en,
  output logic              rf_en_read,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_oe,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;

  logic [DATA_W-1:0] new_lo, new_hi;
  logic [ADDR_W-1:0] lo_addr, hi_addr;
  logic              cmd_ok;

  assign lo_addr = pair_lo(dst_q[1:0]);
  assign hi_addr = pair_hi(dst_q[1:0]);

  rp_incdec u_incdec (
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .dec_i    (op_q == OP_DCX),
    .new_hi_o (new_hi),
    .new_lo_o (new_lo)
  );

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_op)
      OP_MOV:  cmd_ok = reg_code_ok(cmd_dst) && reg_code_ok(cmd_src);
      OP_MVI:  cmd_ok = reg_code_ok(cmd_dst);
      default: cmd_ok = (cmd_dst[1:0] != 2'd3);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dst_d      = dst_q;
    src_d      = src_q;
    tmp_d      = tmp_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cmd_ready  = 1'b0;
    bus_req    = 1'b0;
    rf_en      = 1'b0;
    rf_en_read = 1'b0;
    rf_addr    = '0;
    rf_wr_data = '0;
    rf_wr_oe   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d  = cmd_op;
          dst_d = cmd_dst;
          src_d = cmd_src;
          if (!cmd_ok) begin
            state_d = ST_ERR;
          end else begin
            case (cmd_op)
              OP_MOV: state_d = ST_RD_SRC;
              OP_MVI: begin
                state_d = ST_WR_DST;
                tmp_d   = cmd_imm;
              end
              default: state_d = ST_RD_LO;
            endcase
          end
        end
      end

      // Bus states: without a grant everything but bus_req stays idle and the state holds.
      ST_RD_SRC: begin
        bus_req = 1'b1;
        rf_addr = src_q;
        if (bus_gnt) begin
          rf_en   = 1'b1;
          tmp_d   = rf_rd_data;
          state_d = ST_WR_DST;
        end
      end

      ST_WR_DST: begin
        bus_req = 1'b1;
        rf_addr = dst_q;
        if (bus_gnt) begin
          rf_en      = 1'b1;
          rf_en_read = 1'b1;
          rf_wr_oe   = 1'b1;
          rf_wr_data = tmp_q;
          state_d    = ST_DONE;
        end
      end

      ST_RD_LO: begin
        bus_req = 1'b1;
        rf_addr = lo_addr;
        if (bus_gnt) begin
          rf_en   = 1'b1;
          lo_d    = rf_rd_data;
          state_d = ST_RD_HI;
        end
      end

      ST_RD_HI: begin
        bus_req = 1'b1;
        rf_addr = hi_addr;
        if (bus_gnt) begin
          rf_en   = 1'b1;
          hi_d    = rf_rd_data;
          state_d = ST_WR_LO;
        end
      end

      ST_WR_LO: begin
        bus_req = 1'b1;
        rf_addr = lo_addr;
        if (bus_gnt) begin
          rf_en      = 1'b1;
          rf_en_read = 1'b1;
          rf_wr_oe   = 1'b1;
          rf_wr_data = new_lo;
          state_d    = ST_WR_HI;
        end
      end

      // lo_q/hi_q still hold the original pair, so new_hi is unaffected by the low write.
      ST_WR_HI: begin
        bus_req = 1'b1;
        rf_addr = hi_addr;
        if (bus_gnt) begin
          rf_en      = 1'b1;
          rf_en_read = 1'b1;
          rf_wr_oe   = 1'b1;
          rf_wr_data = new_hi;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MOV;
      dst_q   <= '0;
      src_q   <= '0;
      tmp_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      tmp_q   <= tmp_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq: a register-file bus model, an abstract
// reference model feeding expected accesses/completions, and a negedge monitor.
module tb_regfile_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_dst, cmd_src;
  logic [7:0] cmd_imm;
  logic       bus_req, bus_gnt;
  logic       rf_en, rf_en_read, rf_wr_oe, done, err;
  logic [2:0] rf_addr;
  logic [7:0] rf_rd_data, rf_wr_data;

  always #5 clk = ~clk;

  regfile_seq dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_src    (cmd_src),
    .cmd_imm    (cmd_imm),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .rf_en      (rf_en),
    .rf_en_read (rf_en_read),
    .rf_addr    (rf_addr),
    .rf_rd_data (rf_rd_data),
    .rf_wr_data (rf_wr_data),
    .rf_wr_oe   (rf_wr_oe),
    .done       (done),
    .err        (err)
  );

  typedef struct { bit wr; int addr; int data; } acc_t;
  typedef struct { bit is_err; int lat; int stalls; } exp_t;

  acc_t acc_q[$];
  exp_t exp_q[$];
  int   ref_regs [8];
  logic [7:0] rf_mem [8];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   gnt_mode = 0;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Register file: drives the bus on reads, captures the bus on write strobes.
  assign rf_rd_data = (rf_en && !rf_en_read) ? rf_mem[rf_addr] : 8'h00;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
    end else if (rf_en && rf_en_read) begin
      rf_mem[rf_addr] <= rf_wr_oe ? rf_wr_data : 8'hEE;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Grant driver: 0 always granted, 1 random, 2 four-cycle stall after first bus cycle.
  initial begin
    int bus_cnt;
    bus_cnt = 0;
    bus_gnt = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (gnt_mode == 1) begin
        bus_gnt = ($urandom_range(0, 3) != 0);
      end else if (gnt_mode == 2 && bus_req) begin
        bus_gnt = !(bus_cnt >= 1 && bus_cnt <= 4);
        bus_cnt++;
      end else begin
        bus_gnt = 1'b1;
        if (!bus_req) bus_cnt = 0;
      end
    end
  end

  task automatic push_acc(input bit wr, input int addr, input int data);
    acc_t a;
    a.wr = wr; a.addr = addr; a.data = data;
    acc_q.push_back(a);
  endtask

  // Reference model: architectural effect of one command.
  task automatic model_cmd(input int op, input int dst, input int src, input int imm, input int stalls);
    exp_t e;
    int rp, lo, hi, v;
    e.stalls = stalls;
    e.is_err = 1'b0;
    e.lat    = 1;
    if (op == 0) begin
      if (dst < 1 || dst > 6 || src < 1 || src > 6) e.is_err = 1'b1;
      else begin
        e.lat = 3;
        push_acc(1'b0, src, 0);
        push_acc(1'b1, dst, ref_regs[src]);
        ref_regs[dst] = ref_regs[src];
      end
    end else if (op == 1) begin
      if (dst < 1 || dst > 6) e.is_err = 1'b1;
      else begin
        e.lat = 2;
        push_acc(1'b1, dst, imm);
        ref_regs[dst] = imm;
      end
    end else begin
      rp = dst % 4;
      if (rp == 3) e.is_err = 1'b1;
      else begin
        e.lat = 5;
        lo = 2 * rp + 2;
        hi = 2 * rp + 1;
        v  = ref_regs[hi] * 256 + ref_regs[lo];
        v  = (op == 2) ? (v + 1) % 65536 : (v + 65535) % 65536;
        push_acc(1'b0, lo, 0);
        push_acc(1'b0, hi, 0);
        push_acc(1'b1, lo, v % 256);
        push_acc(1'b1, hi, v / 256);
        ref_regs[lo] = v % 256;
        ref_regs[hi] = v / 256;
      end
    end
    if (e.is_err) e.lat = 1;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int op, input int dst, input int src, input int imm, input int stalls);
    for (int k = 0; k < 50 && !cmd_ready; k++) begin
      @(posedge clk);
      #1;
    end
    model_cmd(op, dst, src, imm, stalls);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_dst   = 3'(dst);
    cmd_src   = 3'(src);
    cmd_imm   = 8'(imm);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic run_cmd(input int op, input int dst, input int src, input int imm, input int stalls);
    issue(op, dst, src, imm, stalls);
    drain();
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_bus_req"}, bus_req, 0);
    chk({tag, "_rf_en"}, rf_en, 0);
    chk({tag, "_rf_en_read"}, rf_en_read, 0);
    chk({tag, "_rf_wr_oe"}, rf_wr_oe, 0);
    chk({tag, "_rf_addr"}, rf_addr, 0);
    chk({tag, "_rf_wr_data"}, rf_wr_data, 0);
  endtask

  // Monitor: pops expected accesses on every rf_en and completions on done/err.
  initial begin
    acc_t a;
    exp_t e;
    int acc_cyc, stall;
    acc_cyc = 0;
    stall   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cmd_valid && cmd_ready) begin
          acc_cyc = cyc;
          stall   = 0;
        end
        if (bus_req && !bus_gnt) begin
          stall++;
          chk("stall_rf_en", rf_en, 0);
        end
        if (rf_en) begin
          chk("rf_en_bus_req", bus_req, 1);
          if (acc_q.size() == 0) chk("spurious_rf_en", rf_en, 0);
          else begin
            a = acc_q.pop_front();
            chk("acc_write", rf_en_read, a.wr);
            chk("acc_oe", rf_wr_oe, a.wr);
            chk("acc_addr", rf_addr, a.addr);
            if (a.wr) chk("acc_data", rf_wr_data, a.data);
          end
        end
        if (done || err) begin
          chk("ready_in_done", cmd_ready, 0);
          if (exp_q.size() == 0) chk("spurious_done_err", int'(done) + int'(err), 0);
          else begin
            e = exp_q.pop_front();
            chk("err_pulse", err, e.is_err);
            chk("done_pulse", done, !e.is_err);
            chk("latency", cyc - acc_cyc - stall, e.lat);
            if (e.stalls >= 0) chk("stall_count", stall, e.stalls);
            chk("acc_left", acc_q.size(), 0);
            for (int r = 1; r <= 6; r++) chk($sformatf("reg%0d", r), rf_mem[r], ref_regs[r]);
            $display("txn %0s lat=%0d stalls=%0d", e.is_err ? "err" : "done", cyc - acc_cyc - stall, stall);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, dst, src;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_dst   = 3'd0;
    cmd_src   = 3'd0;
    cmd_imm   = 8'd0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    gnt_mode = 0;
    run_cmd(1, 1, 0, 'h5A, 0);   // MVI B,5A
    run_cmd(0, 4, 1, 0, 0);      // MOV E,B
    run_cmd(1, 5, 0, 'h12, 0);   // MVI H,12
    run_cmd(1, 6, 0, 'hFF, 0);   // MVI L,FF
    run_cmd(2, 2, 0, 0, 0);      // INX H
    run_cmd(1, 1, 0, 'hFF, 0);
    run_cmd(1, 2, 0, 'hFF, 0);
    run_cmd(2, 0, 0, 0, 0);      // INX B: FFFF -> 0000
    run_cmd(1, 3, 0, 'h00, 0);
    run_cmd(1, 4, 0, 'h00, 0);
    gnt_mode = 2;
    run_cmd(3, 1, 0, 0, 4);      // DCX D with a 4-cycle stall
    gnt_mode = 0;
    run_cmd(1, 7, 0, 'h33, 0);   // illegal MVI dst 7
    run_cmd(0, 1, 0, 0, 0);      // illegal MOV src 0
    run_cmd(0, 0, 2, 0, 0);      // illegal MOV dst 0
    run_cmd(2, 3, 0, 0, 0);      // illegal INX rp 3
    run_cmd(0, 3, 3, 0, 0);      // MOV D,D

    // Reset while INX H sits in RD_HI.
    issue(2, 2, 0, 0, -1);
    for (int k = 0; k < 20 && !(rf_en && !rf_en_read && rf_addr == 3'd5); k++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_rd_hi", rf_addr, 5);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outs("async_reset");
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 8; i++) ref_regs[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_reset_strobe", rf_en_read, 0);
    end

    gnt_mode = 1;
    for (int n = 0; n < 150; n++) begin
      op  = $urandom_range(0, 3);
      dst = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 7) : $urandom_range(1, 6);
      src = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(1, 6);
      if (op >= 2) dst = $urandom_range(0, 3);
      run_cmd(op, dst, src, $urandom_range(0, 255), -1);
    end
    gnt_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
